// File: rtl/dp_burst_mem.sv
// dp_burst_mem: operand RAM with valid/ready burst reader; define DP_BURST_MEM_WR_FWD_EN for write-first read-during-write
module dp_burst_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int MEM_SIZE   = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  done,
  output logic                  err
);
  localparam int IW = $clog2(MEM_SIZE);
  localparam logic [ADDR_WIDTH:0] SIZE = (ADDR_WIDTH+1)'(MEM_SIZE);
  localparam logic [ADDR_WIDTH:0] ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] TOP = ADDR_WIDTH'(MEM_SIZE - 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state;
  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];
  logic [DATA_WIDTH-1:0] rd_data, buf0, buf1;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH:0] rem;
  logic [1:0] cnt, wi;
  logic inflight, rd_last, last0, last1, pop, issue, wr_ok, fwd, bad;
  assign wr_ok = {1'b0, wr_addr} < SIZE;
  assign bad = len == '0 || len > SIZE || {1'b0, base_addr} >= SIZE;
  assign out_valid = cnt != 2'd0;
  assign out_data = buf0;
  assign out_last = out_valid && last0;
  assign pop = out_valid && out_ready;
  // wi is the buffer slot the in-flight word lands in; it also bounds issue so the buffer never overflows
  assign wi = cnt - {1'b0, pop};
  assign issue = state == RUN && ({1'b0, wi} + {2'b0, inflight}) < 3'd2;
`ifdef DP_BURST_MEM_WR_FWD_EN
  assign fwd = wr_en && wr_ok && wr_addr == rd_addr;
`else
  assign fwd = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (wr_en && wr_ok) mem[wr_addr[IW-1:0]] <= wr_data;
    if (issue) begin
      rd_data <= fwd ? wr_data : mem[rd_addr[IW-1:0]];
      rd_last <= rem == ONE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      cnt <= '0;
      inflight <= 1'b0;
      buf0 <= '0;
      last0 <= 1'b0;
      rd_addr <= '0;
      rem <= '0;
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      inflight <= issue;
      cnt <= wi + {1'b0, inflight};
      if (pop) begin
        buf0 <= buf1;
        last0 <= last1;
      end
      if (inflight && wi == 2'd0) begin
        buf0 <= rd_data;
        last0 <= rd_last;
      end
      if (inflight && wi == 2'd1) begin
        buf1 <= rd_data;
        last1 <= rd_last;
      end
      case (state)
        IDLE: if (start) begin
          err <= bad;
          if (!bad) begin
            rd_addr <= base_addr;
            rem <= len;
            busy <= 1'b1;
            state <= RUN;
          end
        end
        RUN: if (issue) begin
          rd_addr <= rd_addr == TOP ? '0 : rd_addr + ADDR_WIDTH'(1);
          rem <= rem - ONE;
          if (rem == ONE) state <= DRAIN;
        end
        DRAIN: if (pop && last0) begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dp_burst_mem.sv
// tb_dp_burst_mem: table-driven burst vectors plus read-during-write and mid-burst reset sequences
module tb_dp_burst_mem;
  localparam int DW = 8;
  localparam int MS = 64;
  localparam int AW = 7;
`ifdef DP_BURST_MEM_WR_FWD_EN
  localparam logic [DW-1:0] RDW_EXP = 8'hA5;
`else
  localparam logic [DW-1:0] RDW_EXP = 8'h55;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0] len = '0;
  logic busy, out_valid, out_last, done, err;
  logic out_ready = 1'b1;
  logic [DW-1:0] out_data;
  int total = 0;
  int fails = 0;
  typedef struct {
    string name;
    logic we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] base;
    logic [AW:0] len;
    logic [15:0] pat;
    int n;
    logic [31:0] exp;
    logic is_err;
  } vec_t;
  vec_t vq[$];
  dp_burst_mem #(.DATA_WIDTH(DW), .MEM_SIZE(MS), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .base_addr(base_addr), .len(len), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", nm, act, want);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask
  function automatic vec_t mk(input string nm, input logic we, input logic [AW-1:0] wa,
                              input logic [DW-1:0] wd, input logic [AW-1:0] b, input logic [AW:0] l,
                              input logic [15:0] p, input int n, input logic [31:0] e, input logic ie);
    vec_t v;
    v.name = nm; v.we = we; v.wa = wa; v.wd = wd; v.base = b; v.len = l;
    v.pat = p; v.n = n; v.exp = e; v.is_err = ie;
    return v;
  endfunction
  task automatic run(input vec_t v);
    int got, c;
    logic seen_err, stalled;
    logic [DW-1:0] hold;
    if (v.we) wr(v.wa, v.wd);
    base_addr = v.base;
    len = v.len;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (v.is_err) begin
      @(negedge clk);
      chk({v.name, "_err"}, err, 1);
      chk({v.name, "_busy"}, busy, 0);
      chk({v.name, "_valid"}, out_valid, 0);
      tick();
      @(negedge clk);
      chk({v.name, "_err_clr"}, err, 0);
      chk({v.name, "_busy2"}, busy, 0);
      chk({v.name, "_valid2"}, out_valid, 0);
      tick();
      return;
    end
    got = 0;
    c = 0;
    seen_err = 1'b0;
    stalled = 1'b0;
    hold = '0;
    while (got < v.n && c < 60) begin
      out_ready = (c < 2 || c > 17) ? 1'b1 : v.pat[c-2];
      start = c == 1;
      len = '0;
      @(negedge clk);
      seen_err |= err;
      if (c == 0) chk({v.name, "_busy"}, busy, 1);
      if (c == 1) chk({v.name, "_lat_lo"}, out_valid, 0);
      if (c == 2) chk({v.name, "_lat_hi"}, out_valid, 1);
      if (stalled) begin
        chk({v.name, "_hold"}, out_data, hold);
        chk({v.name, "_hold_v"}, out_valid, 1);
      end
      stalled = out_valid && !out_ready;
      hold = out_data;
      if (out_valid && out_ready) begin
        chk($sformatf("%s_d%0d", v.name, got), out_data, v.exp[8*got +: 8]);
        chk($sformatf("%s_l%0d", v.name, got), out_last, got == v.n - 1);
        got++;
      end
      tick();
      c++;
    end
    start = 1'b0;
    chk({v.name, "_beats"}, got, v.n);
    if (v.pat == 16'hFFFF) chk({v.name, "_rate"}, c, v.n + 2);
    @(negedge clk);
    seen_err |= err;
    chk({v.name, "_done"}, done, 1);
    chk({v.name, "_busy_end"}, busy, 0);
    tick();
    @(negedge clk);
    chk({v.name, "_done_clr"}, done, 0);
    chk({v.name, "_no_err"}, seen_err, 0);
    tick();
  endtask
  initial begin
    vq.push_back(mk("load", 0, 0, 0, 0, 4, 16'hFFFF, 4, 32'h44332211, 0));
    vq.push_back(mk("bp", 0, 0, 0, 0, 4, 16'hFFE9, 4, 32'h44332211, 0));
    vq.push_back(mk("wrap", 1, 0, 8'hA3, 62, 3, 16'hFFFF, 3, 32'h00A3A2A1, 0));
    vq.push_back(mk("one", 0, 0, 0, 63, 1, 16'hFFFF, 1, 32'h000000A2, 0));
    vq.push_back(mk("len0", 0, 0, 0, 0, 0, 16'hFFFF, 0, 32'h0, 1));
    vq.push_back(mk("len65", 0, 0, 0, 0, 65, 16'hFFFF, 0, 32'h0, 1));
    vq.push_back(mk("base64", 0, 0, 0, 64, 1, 16'hFFFF, 0, 32'h0, 1));
    vq.push_back(mk("restore", 1, 0, 8'h11, 0, 1, 16'hFFFF, 1, 32'h00000011, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_data", out_data, 0);
    tick();
    rst_n = 1'b1;
    wr(0, 8'h11);
    wr(1, 8'h22);
    wr(2, 8'h33);
    wr(3, 8'h44);
    wr(62, 8'hA1);
    wr(63, 8'hA2);
    for (int i = 0; i < vq.size(); i++) run(vq[i]);
    wr(5, 8'h55);
    base_addr = 5;
    len = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wr(5, 8'hA5);
    tick();
    @(negedge clk);
    chk("rdw_valid", out_valid, 1);
    chk("rdw_data", out_data, RDW_EXP);
    chk("rdw_last", out_last, 1);
    tick();
    @(negedge clk);
    chk("rdw_done", done, 1);
    tick();
    run(mk("rdw_after", 0, 0, 0, 5, 1, 16'hFFFF, 1, 32'h000000A5, 0));
    base_addr = 0;
    len = 4;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("mid_b0", out_data, 8'h11);
    tick();
    @(negedge clk);
    chk("mid_b1", out_data, 8'h22);
    tick();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_done2", done, 0);
    chk("mid_rst_err", err, 0);
    tick();
    run(mk("after_rst", 0, 0, 0, 0, 4, 16'hFFFF, 4, 32'h44332211, 0));
    $display("test done: total=%0d bad=%0d", total, fails);
    $finish;
  end
endmodule
